mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported instruction/data memory between three requesters:
//  - instruction fetch (IF)
//  - load/store (LS)
//  - exception-vector read (EX)
//  Grants one access at a time, drives the memory port, counts fixed read
//  latency, returns read data with a one-cycle ack. Sits between uControl-
//  sequenced datapath and memory; replaces hand-counted MEMWAIT states.
// PARAMETERS
//  ADDR_W    32  memory address width
//  DATA_W    32  memory data width
//  READ_LAT  2   cycles from mem_addr valid to mem_rdata valid (legal >= 1)
// PORTS
//  clk        in   1       clock, all state changes on rising edge
//  reset      in   1       asynchronous, active-high
//  if_req     in   1       fetch read request, level, held until if_ack
//  if_addr    in   ADDR_W  fetch address
//  if_ack     out  1       one-cycle pulse: fetch done, rdata valid
//  ls_req     in   1       load/store request, level, held until ls_ack
//  ls_we      in   1       1 = write, 0 = read
//  ls_addr    in   ADDR_W  load/store address
//  ls_wdata   in   DATA_W  store data
//  ls_ack     out  1       one-cycle pulse: LS done (rdata valid if read)
//  ex_req     in   1       exception-vector read request, level
//  ex_addr    in   ADDR_W  vector address
//  ex_ack     out  1       one-cycle pulse: vector read done, rdata valid
//  rdata      out  DATA_W  read data, valid while any *_ack high, held after
//  mem_addr   out  ADDR_W  memory address (registered)
//  mem_wr     out  1       memory write strobe (registered)
//  mem_wdata  out  DATA_W  memory write data (registered)
//  mem_rdata  in   DATA_W  memory read data
//  busy       out  1       1 in BUSY or DONE
//  grant      out  2       00 none, 01 IF, 10 LS, 11 EX; held BUSY..DONE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, cnt 0; any in-flight access is abandoned.
//  FSM IDLE / BUSY / DONE; cnt is a $clog2(READ_LAT+1)-bit counter.
//  IDLE, a req high at the edge:
//  - picks the winner by fixed priority EX > LS > IF
//  - latches addr/we/wdata into mem_addr/mem_wr/mem_wdata
//  - sets grant, busy=1, cnt=0, goes to BUSY
//  - mem_wr = 1 only for an LS write
//  BUSY, each edge:
//  - mem_wr <= 0, so the write strobe is exactly one cycle
//  - cnt <= cnt+1
//  - at the edge where cnt == READ_LAT-1: rdata <= mem_rdata (reads only;
//    rdata holds for writes), winner's ack <= 1, go to DONE
//  DONE, next edge:
//  - ack <= 0, grant <= 00, busy <= 0, mem_addr held, go to IDLE
//  - no request is sampled in DONE, so a req still high with ack high is
//    never re-granted
//  Latency: req seen at edge E0 -> ack high during cycle after E(READ_LAT).
//  Throughput: one access per READ_LAT+2 cycles.
//  Requests are not preempted. ex_req arriving during BUSY waits for IDLE.
//  Req dropped mid-access: the access still completes and ack still pulses.
//  Req inputs and addr/wdata changing after grant are ignored (latched).
//  Simultaneous requests: the loser stays pending and is granted at the first
//  IDLE edge it wins; IF may starve while EX/LS keep requesting (accepted).
//  At most one *_ack high in any cycle; acks and grant are mutually
//  consistent.
// TESTING
//  1 READ_LAT=2, if_req at E0, addr 0x40, mem[0x40]=0xDEADBEEF
//    -> grant=01 after E0; if_ack high only in cycle after E2; rdata=DEADBEEF
//  2 ls_req+if_req together, ls_we=0, ls_addr 0x100
//    -> LS served first (grant 10)
//    -> if_ack comes READ_LAT+2 cycles after ls_ack; no overlap
//  3 LS write addr 0x200, data 0x12345678
//    -> mem_wr high exactly 1 cycle, with mem_addr=0x200, mem_wdata=12345678
//    -> ls_ack pulses; rdata unchanged
//  4 ex_req, ls_req, if_req all at E0
//    -> order EX, LS, IF; each ack a single pulse
//  5 reset asserted mid-BUSY
//    -> immediately busy=0, grant=00, mem_wr=0, no ack
//    -> fresh if_req after reset completes normally
//  6 if_req held high across if_ack
//    -> not regranted in DONE; regranted at following IDLE edge

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: EX > LS > IF fixed-priority arbiter for a single-ported
// memory with fixed read latency and one-cycle ack.        Rev 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  input  logic              ex_req,
  input  logic [ADDR_W-1:0] ex_addr,
  output logic              ex_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        grant
);

  localparam int               CNT_W    = $clog2(READ_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IF   = 2'b01;
  localparam logic [1:0] GNT_LS   = 2'b10;
  localparam logic [1:0] GNT_EX   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic              mem_wr_q,    mem_wr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic              wr_q,        wr_d;
  logic [1:0]        grant_q,     grant_d;
  logic              busy_q,      busy_d;
  logic              if_ack_q,    if_ack_d;
  logic              ls_ack_q,    ls_ack_d;
  logic              ex_ack_q,    ex_ack_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wr_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    wr_d        = wr_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    ex_ack_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_req || ls_req || if_req) begin
          state_d = BUSY;
          cnt_d   = '0;
          busy_d  = 1'b1;
          wr_d    = 1'b0;
          if (ex_req) begin
            grant_d    = GNT_EX;
            mem_addr_d = ex_addr;
          end else if (ls_req) begin
            grant_d     = GNT_LS;
            mem_addr_d  = ls_addr;
            mem_wdata_d = ls_wdata;
            mem_wr_d    = ls_we;
            wr_d        = ls_we;
          end else begin
            grant_d    = GNT_IF;
            mem_addr_d = if_addr;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Writes leave the last read data visible on rdata.
          if (!wr_q) begin
            rdata_d = mem_rdata;
          end
          if_ack_d = (grant_q == GNT_IF);
          ls_ack_d = (grant_q == GNT_LS);
          ex_ack_d = (grant_q == GNT_EX);
          state_d  = DONE;
        end
      end
      DONE: begin
        grant_d = GNT_NONE;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      wr_q        <= 1'b0;
      grant_q     <= GNT_NONE;
      busy_q      <= 1'b0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      ex_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      wr_q        <= wr_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      ex_ack_q    <= ex_ack_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign ls_ack    = ls_ack_q;
  assign ex_ack    = ex_ack_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign grant     = grant_q;

endmodule
`default_nettype wire
